// File: rtl/key_pkg.sv
// Shared types and constants for the push-button input conditioning blocks.
package key_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE        = 2'd0,
    KEY_PRESS_CHK   = 2'd1,
    KEY_PRESSED     = 2'd2,
    KEY_RELEASE_CHK = 2'd3
  } key_state_t;

  // Raw pin level the synchroniser holds in reset: the released (high) state.
  localparam logic KEY_SYNC_RESET = 1'b1;

endpackage

// File: rtl/key_debounce_sync_chain.sv
// Generic multi-flop synchroniser for asynchronous board inputs.
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Push-button synchroniser + 4-state debouncer with press/release strobes and press counter.
// Optional long-press strobe enabled by defining KEY_LONGPRESS_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 8,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             kill,
  input  logic             key,
  output logic             key_level,
  output logic             key_press,
  output logic             key_release,
  output logic [CNT_W-1:0] press_cnt,
  output logic             long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic       key_sync;
  logic       s;
  key_state_t state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (KEY_SYNC_RESET)
  ) u_sync (
    .clk   (clk),
    .rst_n (kill),
    .d     (key),
    .q     (key_sync)
  );

  // Pin is active-low; everything downstream works in pressed=1 terms.
  assign s = ~key_sync;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    pcnt_d    = pcnt_q;
    unique case (state_q)
      KEY_IDLE: begin
        if (s) begin
          state_d = KEY_PRESS_CHK;
          cnt_d   = DW'(1);
        end
      end
      KEY_PRESS_CHK: begin
        if (!s) begin
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = KEY_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          if (pcnt_q != '1) pcnt_d = pcnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      KEY_PRESSED: begin
        if (!s) begin
          state_d = KEY_RELEASE_CHK;
          cnt_d   = DW'(1);
        end
      end
      KEY_RELEASE_CHK: begin
        if (s) begin
          state_d = KEY_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_d   = KEY_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == KEY_PRESSED) || (state_d == KEY_RELEASE_CHK);
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      state_q   <= KEY_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign press_cnt   = pcnt_q;

`ifdef KEY_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          fired_q, fired_d;
  logic          long_q, long_d;
  logic          holding;

  assign holding = (state_q == KEY_PRESSED) || (state_q == KEY_RELEASE_CHK);

  // Hold counter saturates at LONG_CYCLES-1; fired_q limits it to one pulse per press.
  always_comb begin
    hold_d  = hold_q;
    long_d  = holding && (hold_q == HW'(LONG_CYCLES - 1)) && !fired_q;
    fired_d = fired_q | long_d;
    if (press_d || state_d == KEY_IDLE) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (holding && hold_q != HW'(LONG_CYCLES - 1)) begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign long_press = long_q;
`else
  logic unused_long_cycles;
  assign unused_long_cycles = (LONG_CYCLES == 0);
  assign long_press = 1'b0;
`endif

endmodule
